capture_sequencer: RTL and testbench
====================================

# capture_sequencer

Frame-capture controller placed between the sample source (AXI-Stream) and the frame buffer. It arms on request, optionally waits for a level-crossing trigger, then frames exactly `frame_len` samples toward the buffer. The frame opens with a one-cycle `m_tuser` start marker and closes with `m_tlast`. It supports single-shot and continuous capture with a buffer-release handshake, and runs on the buffer's clock, reset and clock-enable.

## Interface
- `DATA_W`, 16, sample width; signed two's complement for trigger compare.
- `LEN_W`, 10, frame length counter width; maximum frame is 2^LEN_W samples.

- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `ce` in 1: clock enable; when low, all state and counters hold.
- `s_tdata` in DATA_W, `s_tvalid` in 1, `s_tready` out 1: sample input stream.
- `m_tdata` out DATA_W, `m_tvalid` out 1, `m_tready` in 1, `m_tlast` out 1, `m_tuser` out 1: output to the buffer.
- `arm` in 1: start request, level-sampled in IDLE.
- `abort` in 1: terminate the current operation.
- `continuous` in 1: 1 selects re-arm after release; sampled at arm.
- `frame_len` in LEN_W: samples per frame; 0 means 2^LEN_W; sampled at arm.
- `trig_level` in DATA_W: trigger threshold.
- `trig_falling` in 1: 0 selects rising edge, 1 selects falling edge.
- `release` in 1: single-cycle pulse; the reader has consumed the buffer.
- `busy` out 1: high in any state other than IDLE.
- `frame_done` out 1: one-cycle pulse per completed frame.
- `aborted` out 1: one-cycle pulse when an abort is processed.
- `frame_cnt` out 16: count of completed frames; wraps at 16 bits.

## Operation
- **States:** IDLE, ARMED, START, CAPTURE, TERM, WAIT_REL.
- **IDLE:** `s_tready`=1, and input samples are discarded. If `arm`=1, latch `frame_len` and `continuous`, then go to ARMED.
- **ARMED:** `s_tready`=1, and samples are discarded.
  - With the trigger compiled in, each accepted sample is compared with the previous accepted sample.
  - Rising trigger: prev < `trig_level` and cur >= `trig_level`.
  - Falling trigger: prev > `trig_level` and cur <= `trig_level`.
  - On a trigger, go to START. The triggering sample is not captured.
  - The previous-sample register is invalidated on entry to ARMED, so the first sample after arming can never trigger.
- **START** (exactly one cycle):
  - `m_tuser`=1, `m_tvalid`=0, `s_tready`=0.
  - Clear the beat counter, then go to CAPTURE.
- **CAPTURE:** combinational pass-through.
  - `m_tdata`=`s_tdata`, `m_tvalid`=`s_tvalid`, `s_tready`=`m_tready`.
  - The beat counter increments on each handshake.
  - `m_tlast`=1 while counter == length−1.
  - On the last handshake: pulse `frame_done`, increment `frame_cnt`. Then go to WAIT_REL if `continuous`, otherwise IDLE.
- **WAIT_REL:** `s_tready`=1, and samples are discarded. On `release`, go to ARMED.
- **abort** (priority over every other transition):
  - From ARMED, START or WAIT_REL: go to IDLE and pulse `aborted`.
  - From CAPTURE: go to TERM.
- **TERM:**
  - `s_tready`=0, `m_tvalid`=1, `m_tdata`=0, `m_tlast`=1, held until `m_tready`.
  - Then go to IDLE and pulse `aborted`. `frame_done` does not pulse.
- **Simultaneous events:**
  - Abort on the final CAPTURE handshake: the frame completes normally, and the abort is ignored.
  - `arm` while busy is ignored.
  - `release` outside WAIT_REL is ignored.
- **Output defaults:** outside CAPTURE and TERM, `m_tdata`=0, `m_tvalid`=0, `m_tlast`=0.

## Timing
- **Reset values:**
  - State is IDLE.
  - `s_tready`=1 and all other outputs are 0.
  - `frame_cnt`=0 and the beat counter is 0.
- **Latency:** state changes register on the clk edge where `ce`=1.
  - `arm` to ARMED: 1 cycle.
  - Trigger sample to START: 1 cycle.
  - START to the first CAPTURE cycle: 1 cycle.
- **Datapath:** zero latency in CAPTURE; `s_tready` depends combinationally on `m_tready`.
- **Pulses:** `frame_done` and `aborted` are registered and high for one `ce`-qualified cycle, in the cycle after the causing handshake.
- **Counter widths:** the beat counter is LEN_W+1 bits. Length 2^LEN_W is represented when `frame_len`=0.
- **Clock enable:** while `ce`=0, outputs hold their registered values.

## Configuration
- Macro `CAPTURE_SEQUENCER_TRIGGER_EN`.
- **Defined:** the comparator and previous-sample register are built; `trig_level` and `trig_falling` are active.
- **Undefined:** ARMED lasts one cycle and goes unconditionally to START; `trig_level` and `trig_falling` are unused.

## Test plan
- **Single shot, no trigger:** `frame_len`=4, pulse `arm`, source sends 1,2,3,4,5 with `m_tready`=1.
  - Expect `m_tuser` in one cycle, then beats 1..4 with `m_tlast` on 4.
  - Then `frame_done` pulse, `frame_cnt`=1, and sample 5 discarded in IDLE.
- **Rising trigger:** `trig_level`=100, source sends 50, 90, 120, 7, 8, `frame_len`=2.
  - Expect the trigger at 120 and the captured frame 7, 8.
  - A first sample of 120 directly after arming must not trigger.
- **Backpressure:** during CAPTURE, `m_tready` toggles 1,0,0,1.
  - `s_tready` must mirror `m_tready` and no beat may be lost or duplicated.
  - The beat counter advances only on handshakes.
- **Continuous mode:** `continuous`=1, `frame_len`=3.
  - After frame 1, stay in WAIT_REL with no `m_tuser` for 20 cycles.
  - Pulse `release`: the second frame is captured and `frame_cnt`=2.
- **Abort mid-frame:** `frame_len`=8, assert `abort` after 3 beats.
  - Expect a TERM beat (data 0, `m_tlast`=1) held through 2 cycles of `m_tready`=0.
  - Then `aborted` pulses, there is no `frame_done`, and the state is IDLE.
- **Reset and `ce`:** drop `reset_n` mid-CAPTURE, and expect all outputs at reset values immediately. With `ce`=0 for 5 cycles in CAPTURE, the counter and outputs are frozen.

Source files
------------

// File: rtl/capture_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : capture_sequencer_if
//  Description : Stream bundle around the capture sequencer. It carries the
//                sample input stream (s_*) from the source and the framed
//                output stream (m_*) toward the frame buffer.
//                  s_tdata/s_tvalid/s_tready : sample input stream
//                  m_tdata/m_tvalid/m_tready : framed output stream
//                  m_tlast                   : last beat of a frame
//                  m_tuser                   : one-cycle frame start marker
//                Modports:
//                  slave  : sequencer view (consumes s_*, produces m_*)
//                  master : environment view (source plus buffer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface capture_sequencer_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tready;

    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              m_tuser;

    modport slave (
        input  s_tdata, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast, m_tuser
    );

    modport master (
        output s_tdata, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast, m_tuser
    );
endinterface
`default_nettype wire

// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : capture_sequencer
//  Description : Frame-capture controller between a sample source and a
//                frame buffer. Arms on request, optionally waits for a
//                level-crossing trigger, then frames exactly frame_len
//                samples (0 means 2^LEN_W). A frame opens with a one-cycle
//                m_tuser marker and closes with m_tlast. Single-shot and
//                continuous (re-arm after buffer release) modes.
//
//  Ports       : clk, reset_n (async, active-low), ce (clock enable)
//                axis         : stream bundle (capture_sequencer_if.slave)
//                arm          : start request, level-sampled in IDLE
//                abort        : terminate current operation
//                continuous   : re-arm after release (sampled at arm)
//                frame_len    : samples per frame (sampled at arm)
//                trig_level   : signed trigger threshold
//                trig_falling : 0 rising edge, 1 falling edge
//                buf_release  : reader has consumed the buffer (pulse).
//                               The natural name "release" is a reserved
//                               word in SystemVerilog.
//                busy         : any state other than IDLE
//                frame_done   : one-cycle pulse per completed frame
//                aborted      : one-cycle pulse per processed abort
//                frame_cnt    : completed frames, wraps at 16 bits
//
//  Config      : `define CAPTURE_SEQUENCER_TRIGGER_EN builds the level
//                crossing trigger. Without it ARMED lasts one cycle and
//                trig_level / trig_falling are unused.
//  Revision    : 1.0 - initial release
// ============================================================================
module capture_sequencer #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 10
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              ce,
    capture_sequencer_if.slave     axis,
    input  wire logic              arm,
    input  wire logic              abort,
    input  wire logic              continuous,
    input  wire logic [LEN_W-1:0]  frame_len,
    input  wire logic [DATA_W-1:0] trig_level,
    input  wire logic              trig_falling,
    input  wire logic              buf_release,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   aborted,
    output logic [15:0]            frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_START    = 3'd2,
        S_CAPTURE  = 3'd3,
        S_TERM     = 3'd4,
        S_WAIT_REL = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    // Frame length is held one bit wider so that frame_len == 0 can be
    // stored as 2^LEN_W.
    logic [LEN_W:0]    len_q;
    logic              cont_q;
    logic [LEN_W:0]    beat_cnt;
    logic              beat_last;

    logic              trig_hit;

    // Combinational stream outputs before they are driven onto the bundle
    logic              s_tready_c;
    logic [DATA_W-1:0] m_tdata_c;
    logic              m_tvalid_c;
    logic              m_tlast_c;
    logic              m_tuser_c;

    // Per-cycle event strobes from the next-state logic
    logic              beat_hs;
    logic              done_set;
    logic              abort_set;

    assign beat_last = (beat_cnt == (len_q - 1'b1));

    // ------------------------------------------------------------------
    // Trigger detection
    // ------------------------------------------------------------------
`ifdef CAPTURE_SEQUENCER_TRIGGER_EN
    logic signed [DATA_W-1:0] prev_sample;
    logic                     prev_valid;
    logic signed [DATA_W-1:0] cur_sample;
    logic signed [DATA_W-1:0] level;
    logic                     cross_rise;
    logic                     cross_fall;

    assign cur_sample = $signed(axis.s_tdata);
    assign level      = $signed(trig_level);
    assign cross_rise = (prev_sample < level) && (cur_sample >= level);
    assign cross_fall = (prev_sample > level) && (cur_sample <= level);

    // Only a sample accepted in ARMED with a valid predecessor can trigger;
    // s_tready is always 1 in ARMED, so s_tvalid alone marks acceptance.
    assign trig_hit = prev_valid && axis.s_tvalid &&
                      (trig_falling ? cross_fall : cross_rise);

    // The history is dropped whenever we are outside ARMED, so every entry
    // into ARMED starts with no previous sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_sample <= '0;
            prev_valid  <= 1'b0;
        end else if (ce) begin
            if (state != S_ARMED) begin
                prev_valid <= 1'b0;
            end else if (axis.s_tvalid) begin
                prev_sample <= cur_sample;
                prev_valid  <= 1'b1;
            end
        end
    end
`else
    assign trig_hit = 1'b1;

    logic unused_trig;
    assign unused_trig = ^{trig_level, trig_falling};
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else if (ce) begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        s_tready_c = 1'b1;
        m_tdata_c  = '0;
        m_tvalid_c = 1'b0;
        m_tlast_c  = 1'b0;
        m_tuser_c  = 1'b0;
        beat_hs    = 1'b0;
        done_set   = 1'b0;
        abort_set  = 1'b0;

        case (state)
            S_IDLE: begin
                if (arm) begin
                    state_next = S_ARMED;
                end
            end

            S_ARMED: begin
                if (abort) begin
                    state_next = S_IDLE;
                    abort_set  = 1'b1;
                end else if (trig_hit) begin
                    state_next = S_START;
                end
            end

            S_START: begin
                m_tuser_c  = 1'b1;
                s_tready_c = 1'b0;
                if (abort) begin
                    state_next = S_IDLE;
                    abort_set  = 1'b1;
                end else begin
                    state_next = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                // Zero-latency pass-through; the buffer shares ce, so both
                // ends of the stream hold together while ce is low.
                m_tdata_c  = axis.s_tdata;
                m_tvalid_c = axis.s_tvalid;
                s_tready_c = axis.m_tready;
                m_tlast_c  = beat_last;
                beat_hs    = axis.s_tvalid && axis.m_tready;
                // The final handshake wins over a simultaneous abort.
                if (beat_hs && beat_last) begin
                    done_set   = 1'b1;
                    state_next = cont_q ? S_WAIT_REL : S_IDLE;
                end else if (abort) begin
                    state_next = S_TERM;
                end
            end

            S_TERM: begin
                // Closing beat for a truncated frame: zero data with tlast.
                s_tready_c = 1'b0;
                m_tvalid_c = 1'b1;
                m_tlast_c  = 1'b1;
                if (axis.m_tready) begin
                    state_next = S_IDLE;
                    abort_set  = 1'b1;
                end
            end

            S_WAIT_REL: begin
                if (abort) begin
                    state_next = S_IDLE;
                    abort_set  = 1'b1;
                end else if (buf_release) begin
                    state_next = S_ARMED;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Configuration latch, beat counter, frame counter and pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q      <= '0;
            cont_q     <= 1'b0;
            beat_cnt   <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
            aborted    <= 1'b0;
        end else if (ce) begin
            frame_done <= done_set;
            aborted    <= abort_set;

            if ((state == S_IDLE) && arm) begin
                len_q  <= {(frame_len == '0), frame_len};
                cont_q <= continuous;
            end

            if (state == S_START) begin
                beat_cnt <= '0;
            end else if (beat_hs) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            if (done_set) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign busy = (state != S_IDLE);

    assign axis.s_tready = s_tready_c;
    assign axis.m_tdata  = m_tdata_c;
    assign axis.m_tvalid = m_tvalid_c;
    assign axis.m_tlast  = m_tlast_c;
    assign axis.m_tuser  = m_tuser_c;

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_capture_sequencer
//  Description : Self-checking bench for capture_sequencer. One table row
//                per clock cycle: inputs applied after the falling edge,
//                outputs compared shortly after, before the rising edge.
//                Registered pulses therefore show up in the row after the
//                cycle that caused them. Async reset is checked by hand.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_sequencer;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 10;

    logic              clk;
    logic              reset_n;
    logic              ce;
    logic              arm;
    logic              abort;
    logic              continuous;
    logic [LEN_W-1:0]  frame_len;
    logic [DATA_W-1:0] trig_level;
    logic              trig_falling;
    logic              buf_release;
    logic              busy;
    logic              frame_done;
    logic              aborted;
    logic [15:0]       frame_cnt;

    capture_sequencer_if #(.DATA_W(DATA_W)) bus ();

    capture_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ce           (ce),
        .axis         (bus),
        .arm          (arm),
        .abort        (abort),
        .continuous   (continuous),
        .frame_len    (frame_len),
        .trig_level   (trig_level),
        .trig_falling (trig_falling),
        .buf_release  (buf_release),
        .busy         (busy),
        .frame_done   (frame_done),
        .aborted      (aborted),
        .frame_cnt    (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        arm, abort, cont, rel, ce, tfall;
        logic [9:0]  flen;
        logic        sv;
        logic [15:0] sd;
        logic        mr;
        logic        x_sready, x_mvalid, x_mlast, x_muser, x_busy, x_done, x_abort;
        logic [15:0] x_mdata, x_fcnt;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   fc       = 0;     // expected frame_cnt for rows being built
    logic b_fall   = 1'b0;  // trigger polarity for rows being built

    // Packed view: {sready, mvalid, mlast, muser, busy, done, aborted, mdata, fcnt}
    function automatic logic [38:0] outs();
        return {bus.s_tready, bus.m_tvalid, bus.m_tlast, bus.m_tuser, busy,
                frame_done, aborted, bus.m_tdata, frame_cnt};
    endfunction

    task automatic check(input string name, input logic [38:0] got, input logic [38:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic add(input logic a, ab, c, r, e, input logic [9:0] fl,
                       input logic sv, input logic [15:0] sd, input logic mr,
                       input logic xs, xv, xl, xu, xb, input logic [15:0] xd,
                       input logic xdone, xab);
        vec_t v;
        v.arm = a; v.abort = ab; v.cont = c; v.rel = r; v.ce = e; v.tfall = b_fall;
        v.flen = fl; v.sv = sv; v.sd = sd; v.mr = mr;
        v.x_sready = xs; v.x_mvalid = xv; v.x_mlast = xl; v.x_muser = xu;
        v.x_busy = xb; v.x_mdata = xd; v.x_done = xdone; v.x_abort = xab;
        v.x_fcnt = 16'(fc);
        tbl.push_back(v);
    endtask

    task automatic idle_r(input logic a, c, input logic [9:0] fl, input logic xdone, xab);
        add(a, 0, c, 0, 1, fl, 0, 0, 0, 1, 0, 0, 0, 0, 0, xdone, xab);
    endtask

    task automatic armed_r(input logic [15:0] sd, input logic sv, input logic ab);
        add(0, ab, 0, 0, 1, 0, sv, sd, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    endtask

    // ARMED phase: one unconditional cycle, or a sample train that must
    // trigger only on its last sample (the leading 120 directly follows
    // arming and has no predecessor).
    task automatic arm_seq();
`ifdef CAPTURE_SEQUENCER_TRIGGER_EN
        if (!b_fall) begin
            armed_r(120, 1, 0); armed_r(50, 1, 0); armed_r(90, 1, 0); armed_r(120, 1, 0);
        end else begin
            armed_r(120, 1, 0); armed_r(150, 1, 0); armed_r(110, 1, 0); armed_r(90, 1, 0);
        end
`else
        armed_r(0, 0, 0);
`endif
    endtask

    task automatic start_r(input logic ab);
        add(0, ab, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    endtask

    task automatic cap_r(input logic [15:0] sd, input logic sv, mr, last, ab);
        add(0, ab, 0, 0, 1, 0, sv, sd, mr, mr, sv, last, 0, 1, sd, 0, 0);
    endtask

    task automatic cap_ce0(input logic [15:0] sd);
        add(0, 0, 0, 0, 0, 0, 1, sd, 1, 1, 1, 0, 0, 1, sd, 0, 0);
    endtask

    task automatic term_r(input logic mr);
        add(0, 0, 0, 0, 1, 0, 0, 0, mr, 0, 1, 1, 0, 1, 0, 0, 0);
    endtask

    task automatic wait_r(input logic a, r, ab, xdone);
        add(a, ab, 0, r, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, xdone, 0);
    endtask

    task automatic build();
        // Single shot, length 4; sample 5 arrives in IDLE and is dropped
        idle_r(0, 0, 0, 0, 0);
        idle_r(1, 0, 4, 0, 0);
        arm_seq(); start_r(0);
        cap_r(1, 1, 1, 0, 0); cap_r(2, 1, 1, 0, 0); cap_r(3, 1, 1, 0, 0); cap_r(4, 1, 1, 1, 0);
        fc = 1;
        add(0, 0, 0, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        idle_r(0, 0, 0, 0, 0);

        // Backpressure 1,0,0,1 and a valid gap, length 3
        idle_r(1, 0, 3, 0, 0);
        arm_seq(); start_r(0);
        cap_r(10, 1, 1, 0, 0); cap_r(11, 1, 0, 0, 0); cap_r(11, 1, 0, 0, 0);
        cap_r(11, 1, 1, 0, 0); cap_r(12, 0, 1, 1, 0); cap_r(12, 1, 1, 1, 0);
        fc = 2;
        idle_r(0, 0, 0, 1, 0);

        // Continuous, length 3; arm while busy ignored; abort in WAIT_REL
        b_fall = 1'b1;
        idle_r(1, 1, 3, 0, 0);
        arm_seq(); start_r(0);
        cap_r(20, 1, 1, 0, 0); cap_r(21, 1, 1, 0, 0); cap_r(22, 1, 1, 1, 0);
        fc = 3;
        wait_r(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) wait_r(i == 5, 0, 0, 0);
        wait_r(0, 1, 0, 0);
        arm_seq(); start_r(0);
        cap_r(30, 1, 1, 0, 0); cap_r(31, 1, 1, 0, 0); cap_r(32, 1, 1, 1, 0);
        fc = 4;
        wait_r(0, 0, 0, 1);
        wait_r(0, 0, 1, 0);
        idle_r(0, 0, 0, 0, 1);
        b_fall = 1'b0;

        // Abort after 3 beats of 8; TERM beat held through 2 stalls
        idle_r(1, 0, 8, 0, 0);
        arm_seq(); start_r(0);
        cap_r(40, 1, 1, 0, 0); cap_r(41, 1, 1, 0, 0); cap_r(42, 1, 1, 0, 0);
        cap_r(43, 0, 1, 0, 1);
        term_r(0); term_r(0); term_r(1);
        idle_r(0, 0, 0, 0, 1);
        idle_r(0, 0, 0, 0, 0);

        // Abort in ARMED, abort in START
        idle_r(1, 0, 2, 0, 0);
        armed_r(0, 0, 1);
        idle_r(0, 0, 0, 0, 1);
        idle_r(1, 0, 2, 0, 0);
        arm_seq(); start_r(1);
        idle_r(0, 0, 0, 0, 1);

        // Abort on the final handshake of a 1-beat frame is ignored
        idle_r(1, 0, 1, 0, 0);
        arm_seq(); start_r(0);
        cap_r(50, 1, 1, 1, 1);
        fc = 5;
        idle_r(0, 0, 0, 1, 0);

        // ce low: arm not taken; capture frozen for 5 cycles; pulse held
        add(1, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle_r(0, 0, 0, 0, 0);
        idle_r(1, 0, 3, 0, 0);
        arm_seq(); start_r(0);
        cap_r(60, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) cap_ce0(61);
        cap_r(61, 1, 1, 0, 0); cap_r(62, 1, 1, 1, 0);
        fc = 6;
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        idle_r(0, 0, 0, 1, 0);
        idle_r(0, 0, 0, 0, 0);

        // release in IDLE ignored
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle_r(0, 0, 0, 0, 0);

        // frame_len 0 means 1024 beats, tlast only on the 1024th
        idle_r(1, 0, 0, 0, 0);
        arm_seq(); start_r(0);
        for (int i = 0; i < 1024; i++) cap_r(16'(i), 1, 1, i == 1023, 0);
        fc = 7;
        idle_r(0, 0, 0, 1, 0);

        // Leave the DUT mid-CAPTURE for the async reset check
        idle_r(1, 0, 4, 0, 0);
        arm_seq(); start_r(0);
        cap_r(70, 1, 1, 0, 0); cap_r(71, 1, 1, 0, 0);
    endtask

    localparam logic [38:0] RESET_OUTS = {1'b1, 6'b0, 16'd0, 16'd0};

    initial begin
        reset_n = 1'b0; ce = 1'b1; arm = 0; abort = 0; continuous = 0;
        frame_len = '0; trig_level = 16'd100; trig_falling = 0; buf_release = 0;
        bus.s_tdata = '0; bus.s_tvalid = 0; bus.m_tready = 0;

        build();

        repeat (3) @(negedge clk);
        #1;
        check("reset_state", outs(), RESET_OUTS);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            arm          = tbl[i].arm;
            abort        = tbl[i].abort;
            continuous   = tbl[i].cont;
            buf_release  = tbl[i].rel;
            ce           = tbl[i].ce;
            trig_falling = tbl[i].tfall;
            frame_len    = tbl[i].flen;
            bus.s_tvalid = tbl[i].sv;
            bus.s_tdata  = tbl[i].sd;
            bus.m_tready = tbl[i].mr;
            #1;
            check($sformatf("row%0d", i), outs(),
                  {tbl[i].x_sready, tbl[i].x_mvalid, tbl[i].x_mlast, tbl[i].x_muser,
                   tbl[i].x_busy, tbl[i].x_done, tbl[i].x_abort, tbl[i].x_mdata,
                   tbl[i].x_fcnt});
        end

        // Async reset in the middle of a capture
        @(negedge clk);
        arm = 0; abort = 0; buf_release = 0; ce = 1;
        bus.s_tvalid = 1; bus.s_tdata = 16'd72; bus.m_tready = 1;
        #1;
        check("pre_reset_capture", outs(),
              {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd72, 16'd7});
        reset_n = 1'b0;
        #1;
        check("async_reset_immediate", outs(), RESET_OUTS);
        @(negedge clk);
        #1;
        check("reset_held", outs(), RESET_OUTS);
        reset_n = 1'b1;
        @(negedge clk);
        bus.s_tvalid = 0; bus.s_tdata = 0;
        #1;
        check("after_reset_idle", outs(), RESET_OUTS);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
